// File: rtl/fc_sched_pkg.sv
// Shared definitions for the FC tile scheduler: FSM states and result-block geometry.
package fc_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_STORE,
    ST_DONE
  } sched_state_t;

  localparam int NUM_CORE = 4;
  // Low address bits that select the word within one tile's result block
  localparam int WSEL_W = 2;

endpackage

// File: rtl/fc_result_writer.sv
// Captures the per-core mover results and streams them onto the result BRAM
// write port as consecutive words at {tile_idx, word}.
module fc_result_writer
  import fc_sched_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 12,
  parameter int TILE_BIT = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                capture,
  input  logic [TILE_BIT-1:0] tile_idx,
  input  logic [DWIDTH-1:0]   result_0,
  input  logic [DWIDTH-1:0]   result_1,
  input  logic [DWIDTH-1:0]   result_2,
  input  logic [DWIDTH-1:0]   result_3,
  output logic [AWIDTH-1:0]   o_addr,
  output logic                o_ce,
  output logic                o_we,
  output logic [DWIDTH-1:0]   o_d,
  output logic                last
);

  logic [DWIDTH-1:0] res_q [NUM_CORE];
  logic [WSEL_W-1:0] word;
  logic              busy;

  // The address wraps modulo 2^AWIDTH: the cast drops or zero-fills upper bits
  function automatic logic [AWIDTH-1:0] word_addr(input logic [TILE_BIT-1:0] t,
                                                  input logic [WSEL_W-1:0]   w);
    logic [TILE_BIT+WSEL_W-1:0] full;
    full = {t, w};
    return AWIDTH'(full);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q  <= '{default: '0};
      word   <= '0;
      busy   <= 1'b0;
      o_addr <= '0;
      o_ce   <= 1'b0;
      o_we   <= 1'b0;
      o_d    <= '0;
      last   <= 1'b0;
    end else begin
      last <= 1'b0;
      if (capture) begin
        // Word 0 goes straight from the inputs so the write starts on the capture edge
        res_q[0] <= result_0;
        res_q[1] <= result_1;
        res_q[2] <= result_2;
        res_q[3] <= result_3;
        o_d      <= result_0;
        o_addr   <= word_addr(tile_idx, '0);
        o_ce     <= 1'b1;
        o_we     <= 1'b1;
        word     <= WSEL_W'(1);
        busy     <= 1'b1;
      end else if (busy) begin
        o_d    <= res_q[word];
        o_addr <= word_addr(tile_idx, word);
        word   <= word + WSEL_W'(1);
        last   <= (word == WSEL_W'(NUM_CORE - 1));
        busy   <= (word != WSEL_W'(NUM_CORE - 1));
      end else begin
        o_ce <= 1'b0;
        o_we <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fc_tile_scheduler.sv
// Runs the FC-core data mover once per tile and stores each tile's 4 results in
// the result BRAM. Optional watchdog enabled by defining FC_SCHED_TIMEOUT_EN.
module fc_tile_scheduler
  import fc_sched_pkg::*;
#(
  parameter int CNT_BIT  = 31,
  parameter int TILE_BIT = 8,
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 12
`ifdef FC_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT  = 65535
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_run,
  input  logic [TILE_BIT-1:0] i_num_tile,
  input  logic [CNT_BIT-1:0]  i_tile_len,
  output logic                o_idle,
  output logic                o_running,
  output logic                o_done,
  output logic [TILE_BIT-1:0] o_tile_idx,
  output logic                o_error,
  output logic                o_mv_run,
  output logic [CNT_BIT-1:0]  o_mv_num_cnt,
  input  logic                i_mv_idle,
  input  logic                i_mv_done,
  input  logic [DWIDTH-1:0]   i_result_0,
  input  logic [DWIDTH-1:0]   i_result_1,
  input  logic [DWIDTH-1:0]   i_result_2,
  input  logic [DWIDTH-1:0]   i_result_3,
  output logic [AWIDTH-1:0]   o_addr,
  output logic                o_ce,
  output logic                o_we,
  output logic [DWIDTH-1:0]   o_d
);

  sched_state_t        state;
  logic [TILE_BIT-1:0] num_tile;
  logic                mv_done_ok;
  logic                wr_last;

  // A done coinciding with our own launch pulse cannot belong to this run
  assign mv_done_ok = (state == ST_WAIT) && i_mv_done && !o_mv_run;

`ifdef FC_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;
  assign wd_hit = (wd_cnt == WD_W'(TIMEOUT));
`else
  assign o_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      num_tile     <= '0;
      o_mv_num_cnt <= '0;
      o_tile_idx   <= '0;
      o_idle       <= 1'b1;
      o_running    <= 1'b0;
      o_done       <= 1'b0;
      o_mv_run     <= 1'b0;
`ifdef FC_SCHED_TIMEOUT_EN
      wd_cnt       <= '0;
      o_error      <= 1'b0;
`endif
    end else begin
      o_mv_run <= 1'b0;
      o_done   <= 1'b0;
`ifdef FC_SCHED_TIMEOUT_EN
      wd_cnt <= (state == ST_LAUNCH || state == ST_WAIT) ? wd_cnt + WD_W'(1) : '0;
`endif
      case (state)
        ST_IDLE: begin
          if (i_run) begin
            num_tile     <= i_num_tile;
            o_mv_num_cnt <= i_tile_len;
            o_tile_idx   <= '0;
            o_idle       <= 1'b0;
`ifdef FC_SCHED_TIMEOUT_EN
            o_error      <= 1'b0;
`endif
            if (i_num_tile == '0 || i_tile_len == '0) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end else begin
              state     <= ST_LAUNCH;
              o_running <= 1'b1;
            end
          end
        end
        ST_LAUNCH: begin
          if (i_mv_idle) begin
            o_mv_run <= 1'b1;
            state    <= ST_WAIT;
`ifdef FC_SCHED_TIMEOUT_EN
            wd_cnt   <= '0;
          end else if (wd_hit) begin
            state     <= ST_DONE;
            o_running <= 1'b0;
            o_done    <= 1'b1;
            o_error   <= 1'b1;
`endif
          end
        end
        ST_WAIT: begin
          if (mv_done_ok) begin
            state <= ST_STORE;
`ifdef FC_SCHED_TIMEOUT_EN
          end else if (wd_hit) begin
            state     <= ST_DONE;
            o_running <= 1'b0;
            o_done    <= 1'b1;
            o_error   <= 1'b1;
`endif
          end
        end
        ST_STORE: begin
          if (wr_last) begin
            if (o_tile_idx == num_tile - TILE_BIT'(1)) begin
              state     <= ST_DONE;
              o_running <= 1'b0;
              o_done    <= 1'b1;
            end else begin
              o_tile_idx <= o_tile_idx + TILE_BIT'(1);
              state      <= ST_LAUNCH;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          o_idle <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          o_idle    <= 1'b1;
          o_running <= 1'b0;
        end
      endcase
    end
  end

  fc_result_writer #(
    .DWIDTH  (DWIDTH),
    .AWIDTH  (AWIDTH),
    .TILE_BIT(TILE_BIT)
  ) u_writer (
    .clk     (clk),
    .reset_n (reset_n),
    .capture (mv_done_ok),
    .tile_idx(o_tile_idx),
    .result_0(i_result_0),
    .result_1(i_result_1),
    .result_2(i_result_2),
    .result_3(i_result_3),
    .o_addr  (o_addr),
    .o_ce    (o_ce),
    .o_we    (o_we),
    .o_d     (o_d),
    .last    (wr_last)
  );

endmodule

// File: tb/tb_fc_tile_scheduler.sv
// Randomized self-checking bench for fc_tile_scheduler with a behavioural mover
// model and a result-BRAM scoreboard; define FC_SCHED_TIMEOUT_EN to cover the watchdog.
module tb_fc_tile_scheduler;

  localparam int CNT_BIT   = 31;
  localparam int TILE_BIT  = 8;
  localparam int DWIDTH    = 32;
  localparam int AWIDTH    = 8;
  localparam int MEM_WORDS = 1 << AWIDTH;

  logic                clk;
  logic                reset_n;
  logic                i_run;
  logic [TILE_BIT-1:0] i_num_tile;
  logic [CNT_BIT-1:0]  i_tile_len;
  logic                o_idle, o_running, o_done, o_error, o_mv_run;
  logic [TILE_BIT-1:0] o_tile_idx;
  logic [CNT_BIT-1:0]  o_mv_num_cnt;
  logic                i_mv_idle, i_mv_done;
  logic [DWIDTH-1:0]   i_result_0, i_result_1, i_result_2, i_result_3;
  logic [AWIDTH-1:0]   o_addr;
  logic                o_ce, o_we;
  logic [DWIDTH-1:0]   o_d;

  fc_tile_scheduler #(
    .CNT_BIT (CNT_BIT),
    .TILE_BIT(TILE_BIT),
    .DWIDTH  (DWIDTH),
    .AWIDTH  (AWIDTH)
`ifdef FC_SCHED_TIMEOUT_EN
    ,
    .TIMEOUT (100)
`endif
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_run       (i_run),
    .i_num_tile  (i_num_tile),
    .i_tile_len  (i_tile_len),
    .o_idle      (o_idle),
    .o_running   (o_running),
    .o_done      (o_done),
    .o_tile_idx  (o_tile_idx),
    .o_error     (o_error),
    .o_mv_run    (o_mv_run),
    .o_mv_num_cnt(o_mv_num_cnt),
    .i_mv_idle   (i_mv_idle),
    .i_mv_done   (i_mv_done),
    .i_result_0  (i_result_0),
    .i_result_1  (i_result_1),
    .i_result_2  (i_result_2),
    .i_result_3  (i_result_3),
    .o_addr      (o_addr),
    .o_ce        (o_ce),
    .o_we        (o_we),
    .o_d         (o_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Reference state: job bookkeeping plus the expected BRAM write stream
  int  cyc = 0;
  int  exp_len = 0;
  int  mv_run_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int  mv_delay = 20, mv_left = 0;
  int  first_run_cyc = -1, idle_rise_cyc = -1, done_cyc = -1;
  bit  mv_busy = 0, hold_low = 0, mv_never = 0, fixed_results = 0, spurious_en = 0;
  logic [AWIDTH-1:0] exp_addr[$];
  logic [DWIDTH-1:0] exp_data[$];
  int                exp_word[$];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Mover model and write monitor, sampled on the falling edge
  initial begin
    logic [DWIDTH-1:0] res [4];
    logic [AWIDTH-1:0] a;
    logic [DWIDTH-1:0] d;
    int                w, t;
    bit                nxt_idle;
    i_mv_idle = 1'b1;
    i_mv_done = 1'b0;
    {i_result_0, i_result_1, i_result_2, i_result_3} = '0;
    forever begin
      @(negedge clk);
      cyc++;
      i_mv_done = 1'b0;
      if (!reset_n) begin
        mv_busy   = 0;
        i_mv_idle = 1'b1;
        exp_addr.delete();
        exp_data.delete();
        exp_word.delete();
      end else begin
        if (o_we) begin
          wr_cnt++;
          if (exp_data.size() == 0) begin
            checkOutput("write_unexpected", 1, 0);
          end else begin
            a = exp_addr.pop_front();
            d = exp_data.pop_front();
            w = exp_word.pop_front();
            checkOutput("wr_addr", o_addr, a);
            checkOutput("wr_data", o_d, d);
            checkOutput("wr_ce", o_ce, 1);
            if (w == 64 * 4) checkOutput("wrap_t64_addr", o_addr, 0);
          end
        end
        if (o_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (o_idle) mv_busy = 0;
        if (o_mv_run) begin
          checkOutput("mv_num_cnt", o_mv_num_cnt, exp_len);
          checkOutput("mv_tile_idx", o_tile_idx, mv_run_cnt);
          if (mv_run_cnt == 0) first_run_cyc = cyc;
          mv_run_cnt++;
          mv_busy = 1;
          mv_left = mv_delay;
          if (spurious_en) begin
            i_mv_done  = 1'b1;
            i_result_0 = $urandom;
            i_result_1 = $urandom;
            i_result_2 = $urandom;
            i_result_3 = $urandom;
          end
        end else if (mv_busy && !mv_never) begin
          mv_left--;
          if (mv_left <= 0) begin
            t = mv_run_cnt - 1;
            for (int k = 0; k < 4; k++) begin
              res[k] = fixed_results ? DWIDTH'(16 * t + k) : DWIDTH'($urandom);
              exp_addr.push_back(AWIDTH'((t * 4 + k) % MEM_WORDS));
              exp_data.push_back(res[k]);
              exp_word.push_back(t * 4 + k);
            end
            i_result_0 = res[0];
            i_result_1 = res[1];
            i_result_2 = res[2];
            i_result_3 = res[3];
            i_mv_done  = 1'b1;
            mv_busy    = 0;
          end
        end
        nxt_idle = !mv_busy && !hold_low;
        if (nxt_idle && !i_mv_idle && mv_run_cnt == 0) idle_rise_cyc = cyc;
        i_mv_idle = nxt_idle;
      end
    end
  end

  task automatic applyStimulus(input int n, input int len);
    @(negedge clk);
    mv_run_cnt    = 0;
    wr_cnt        = 0;
    done_cnt      = 0;
    first_run_cyc = -1;
    idle_rise_cyc = -1;
    exp_len       = len;
    i_num_tile    = TILE_BIT'(n);
    i_tile_len    = CNT_BIT'(len);
    i_run         = 1'b1;
    @(negedge clk);
    i_run      = 1'b0;
    i_num_tile = TILE_BIT'($urandom);
    i_tile_len = CNT_BIT'($urandom);
  endtask

  task automatic waitDone(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (o_done) seen = 1;
    end
    checkOutput("done_seen", seen, 1);
  endtask

  task automatic finishJob(input int n, input int budget);
    waitDone(budget);
    repeat (3) @(negedge clk);
    checkOutput("job_done_cnt", done_cnt, 1);
    checkOutput("job_mv_runs", mv_run_cnt, n);
    checkOutput("job_writes", wr_cnt, 4 * n);
    checkOutput("job_pending", exp_data.size(), 0);
    checkOutput("job_idle", o_idle, 1);
    checkOutput("job_running", o_running, 0);
    checkOutput("job_error", o_error, 0);
  endtask

  task automatic zeroJob(input int n, input int len);
    applyStimulus(n, len);
    checkOutput("zero_done_now", o_done, 1);
    checkOutput("zero_idle_low", o_idle, 0);
    @(negedge clk);
    checkOutput("zero_done_pulse", o_done, 0);
    checkOutput("zero_idle_back", o_idle, 1);
    repeat (3) @(negedge clk);
    checkOutput("zero_mv_runs", mv_run_cnt, 0);
    checkOutput("zero_writes", wr_cnt, 0);
    checkOutput("zero_done_cnt", done_cnt, 1);
  endtask

  initial begin
    bit found;
    reset_n    = 1'b0;
    i_run      = 1'b0;
    i_num_tile = '0;
    i_tile_len = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_idle", o_idle, 1);
    checkOutput("rst_running", o_running, 0);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_mv_run", o_mv_run, 0);
    checkOutput("rst_tile_idx", o_tile_idx, 0);
    checkOutput("rst_num_cnt", o_mv_num_cnt, 0);
    checkOutput("rst_we", o_we, 0);
    checkOutput("rst_ce", o_ce, 0);
    checkOutput("rst_addr", o_addr, 0);
    checkOutput("rst_d", o_d, 0);
    checkOutput("rst_error", o_error, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three tiles with recognisable results 0x10*t + k
    fixed_results = 1;
    mv_delay = 20;
    applyStimulus(3, 16);
    finishJob(3, 2000);
    fixed_results = 0;

    zeroJob(0, 16);
    zeroJob(5, 0);

    // Mover held busy: launch must follow the idle rise, a second i_run is ignored
    hold_low = 1;
    mv_delay = 4;
    repeat (2) @(negedge clk);
    applyStimulus(2, 33);
    repeat (10) @(negedge clk);
    checkOutput("hold_running", o_running, 1);
    checkOutput("hold_no_run", mv_run_cnt, 0);
    i_num_tile = TILE_BIT'(7);
    i_run = 1'b1;
    @(negedge clk);
    i_run = 1'b0;
    repeat (37) @(negedge clk);
    hold_low = 0;
    finishJob(2, 1000);
    checkOutput("hold_run_after_rise", first_run_cyc - idle_rise_cyc, 1);

    // Asynchronous reset in the middle of tile 1's store burst
    mv_delay = 5;
    applyStimulus(3, 12);
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (o_we && o_tile_idx == TILE_BIT'(1)) found = 1;
    end
    checkOutput("reach_store_t1", found, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("arst_idle", o_idle, 1);
    checkOutput("arst_running", o_running, 0);
    checkOutput("arst_we", o_we, 0);
    checkOutput("arst_ce", o_ce, 0);
    checkOutput("arst_addr", o_addr, 0);
    checkOutput("arst_d", o_d, 0);
    checkOutput("arst_tile_idx", o_tile_idx, 0);
    checkOutput("arst_num_cnt", o_mv_num_cnt, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("arst_no_done", done_cnt, 0);
    applyStimulus(1, 7);
    finishJob(1, 500);

    // Randomized jobs, with spurious done pulses in the launch cycle
    for (int j = 0; j < 4; j++) begin
      int n, len;
      n = $urandom_range(1, 6);
      len = $urandom_range(1, 2000);
      mv_delay = $urandom_range(1, 8);
      spurious_en = 1'($urandom_range(0, 1));
      applyStimulus(n, len);
      finishJob(n, 2000);
    end

    // Maximum tile count: addresses wrap every 64 tiles
    mv_delay = 2;
    spurious_en = 1;
    applyStimulus(255, 100);
    finishJob(255, 8000);
    spurious_en = 0;

`ifdef FC_SCHED_TIMEOUT_EN
    // Mover never finishes: watchdog ends the job 101 cycles into WAIT
    mv_never = 1;
    mv_delay = 3;
    applyStimulus(2, 9);
    waitDone(400);
    repeat (3) @(negedge clk);
    checkOutput("to_latency", done_cyc - first_run_cyc, 101);
    checkOutput("to_error_sticky", o_error, 1);
    checkOutput("to_mv_runs", mv_run_cnt, 1);
    checkOutput("to_writes", wr_cnt, 0);
    checkOutput("to_done_cnt", done_cnt, 1);
    mv_never = 0;
    applyStimulus(1, 3);
    checkOutput("to_error_clear", o_error, 0);
    finishJob(1, 500);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
